// File: rtl/jedro_1_ifu_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch unit.
package jedro_1_ifu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned INSTR_BYTES    = 4;
  localparam logic [ADDR_WIDTH_DEF-1:0] BOOT_ADDR_DEF = 32'h0000_0000;

  // Entry widths are fixed here; the top-level width parameters must match them.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; push while full is
// accepted only when a pop happens in the same cycle.
module jedro_1_ifu_fifo
  import jedro_1_ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: sequential PC, credit-limited ROM requests,
// prefetch buffering and jump flush/redirect.
module jedro_1_ifu
  import jedro_1_ifu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEF,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  instr_en_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  jmp_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [DATA_WIDTH-1:0] dec_instr_o,
  output logic [ADDR_WIDTH-1:0] dec_pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  drop_q, drop_d;

  logic                  fetch_req, push, pop;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_used;
  logic                  fifo_full, fifo_empty;
  fetch_entry_t          push_entry, head_entry;

  // An outstanding request reserves a slot so its response can never overflow.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign fetch_req   = ~rst_i & ~fifo_full & (credit_used < (CW+1)'(FIFO_DEPTH));

  assign push = inflight_q & ~drop_q & ~jmp_i;
  assign pop  = ~fifo_empty & dec_ready_i;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = instr_rdata_i;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = fetch_req;
    drop_d     = 1'b0;
    if (fetch_req) begin
      pc_d     = pc_q + ADDR_WIDTH'(INSTR_BYTES);
      req_pc_d = pc_q;
    end
    // A redirect overrides the sequential PC and orphans any outstanding response.
    if (jmp_i) begin
      pc_d       = jmp_addr_i & ~ADDR_WIDTH'(INSTR_BYTES - 1);
      inflight_d = 1'b0;
      drop_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= BOOT_ADDR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  jedro_1_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (jmp_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign instr_en_o   = fetch_req;
  assign instr_addr_o = pc_q;
  assign dec_valid_o  = ~fifo_empty;
  assign dec_instr_o  = fifo_empty ? '0 : head_entry.instr;
  assign dec_pc_o     = fifo_empty ? '0 : head_entry.pc;

endmodule
